frame_demux_1to2: RTL and testbench

//  Frame-atomic 1-to-2 demultiplexer for the frame interface (val/rdy + sof/eof/sol/eol).

---
 rtl/frame_demux_1to2_if.sv | 15 +
 rtl/frame_demux_1to2.sv | 167 ++++++++++++++++
 tb/tb_frame_demux_1to2.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_demux_1to2_if.sv
// rtl/frame_demux_1to2_if.sv - val/rdy pixel stream carrying sof/eof/sol/eol framing flags
interface frame_demux_1to2_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  val;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] data;
  logic                  sof;
  logic                  eof;
  logic                  sol;
  logic                  eol;

  modport master (output val, data, sof, eof, sol, eol, input rdy);
  modport slave  (input val, data, sof, eof, sol, eol, output rdy);
endinterface

// File: rtl/frame_demux_1to2.sv
// rtl/frame_demux_1to2.sv - frame-atomic 1-to-2 stream demux, one registered output stage
// Optional per-output completed-frame counters with FRM_DEMUX_CNT_EN.
module frame_demux_1to2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel,
  frame_demux_1to2_if.slave        in_frm,
  frame_demux_1to2_if.master       out0_frm,
  frame_demux_1to2_if.master       out1_frm
`ifdef FRM_DEMUX_CNT_EN
  ,
  output logic [15:0]              frm_cnt0,
  output logic [15:0]              frm_cnt1
`endif
);

  typedef enum logic {
    IDLE,
    ROUTE
  } state_e;

  state_e                state_q, state_d;
  logic                  hold_val_q, hold_val_d;
  logic                  dest_q, dest_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic                  sol_q, sol_d;
  logic                  eol_q, eol_d;

  logic dest_rdy;
  logic fwd_rdy;
  logic drain;
  logic in_rdy;
  logic accept;
  logic load;

  // A new beat may load only once the held beat leaves towards its own destination,
  // so a destination change can never overtake or drop the previous frame's tail.
  assign dest_rdy = dest_q ? out1_frm.rdy : out0_frm.rdy;
  assign fwd_rdy  = ~hold_val_q | dest_rdy;
  assign drain    = hold_val_q & dest_rdy;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    in_rdy  = fwd_rdy;
    accept  = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        // Stray beats outside a frame are swallowed without waiting on downstream.
        if (!in_frm.sof) begin
          in_rdy = 1'b1;
        end
        accept = in_frm.val & in_rdy;
        if (accept && in_frm.sof) begin
          load   = 1'b1;
          dest_d = sel;
          if (!in_frm.eof) begin
            state_d = ROUTE;
          end
        end
      end
      ROUTE: begin
        accept = in_frm.val & in_rdy;
        if (accept) begin
          load = 1'b1;
          // A sof inside a frame means the previous frame was truncated; rebind here.
          if (in_frm.sof) begin
            dest_d = sel;
          end
          if (in_frm.eof) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    hold_val_d = hold_val_q;
    data_d     = data_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    sol_d      = sol_q;
    eol_d      = eol_q;
    if (load) begin
      hold_val_d = 1'b1;
      data_d     = in_frm.data;
      sof_d      = in_frm.sof;
      eof_d      = in_frm.eof;
      sol_d      = in_frm.sol;
      eol_d      = in_frm.eol;
    end else if (drain) begin
      hold_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_val_q <= 1'b0;
      dest_q     <= 1'b0;
      data_q     <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_val_q <= hold_val_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      sol_q      <= sol_d;
      eol_q      <= eol_d;
    end
  end

  assign in_frm.rdy   = in_rdy;

  assign out0_frm.val  = hold_val_q & ~dest_q;
  assign out0_frm.data = data_q;
  assign out0_frm.sof  = sof_q;
  assign out0_frm.eof  = eof_q;
  assign out0_frm.sol  = sol_q;
  assign out0_frm.eol  = eol_q;

  assign out1_frm.val  = hold_val_q & dest_q;
  assign out1_frm.data = data_q;
  assign out1_frm.sof  = sof_q;
  assign out1_frm.eof  = eof_q;
  assign out1_frm.sol  = sol_q;
  assign out1_frm.eol  = eol_q;

`ifdef FRM_DEMUX_CNT_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q + 16'(out0_frm.val & out0_frm.rdy & eof_q);
    cnt1_d = cnt1_q + 16'(out1_frm.val & out1_frm.rdy & eof_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign frm_cnt0 = cnt0_q;
  assign frm_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_frame_demux_1to2.sv
// tb/tb_frame_demux_1to2.sv - bench for frame_demux_1to2: vector table plus scoreboard
// Counter checks are compiled in when FRM_DEMUX_CNT_EN is defined.
module tb_frame_demux_1to2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  always #5 clk = ~clk;

  frame_demux_1to2_if #(.DATA_WIDTH(DW)) in_if ();
  frame_demux_1to2_if #(.DATA_WIDTH(DW)) o0_if ();
  frame_demux_1to2_if #(.DATA_WIDTH(DW)) o1_if ();

`ifdef FRM_DEMUX_CNT_EN
  logic [15:0] frm_cnt0, frm_cnt1;
`endif

  frame_demux_1to2 #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .in_frm   (in_if),
    .out0_frm (o0_if),
    .out1_frm (o1_if)
`ifdef FRM_DEMUX_CNT_EN
    ,
    .frm_cnt0 (frm_cnt0),
    .frm_cnt1 (frm_cnt1)
`endif
  );

  typedef struct {
    logic       sel;
    logic       sof;
    logic       eof;
    logic       sol;
    logic       eol;
    logic [7:0] data;
    int         exp_dest;  // 0/1 = output port, 2 = dropped
    bit         chk_rdy;
  } vec_t;

  typedef struct {
    logic [11:0] beat;
    int          stamp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rnd_val = 1'b0;
  bit   rnd_rdy = 1'b0;
  bit   chk_lat = 1'b0;
  logic r0 = 1'b1;
  logic r1 = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic s, input int i, input logic [7:0] d,
                              input int e, input bit c);
    vec_t v;
    v.sel      = s;
    v.sof      = (i == 0);
    v.eof      = (i == 7);
    v.sol      = (i % 4 == 0);
    v.eol      = (i % 4 == 3);
    v.data     = d;
    v.exp_dest = e;
    v.chk_rdy  = c;
    return v;
  endfunction

  task automatic pop_chk(input int n, input logic [11:0] act);
    exp_t e;
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL out%0d_unexpected: got beat %0h expected none (cycle %0d)", n, act, cyc);
      return;
    end
    if (n == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("out%0d_beat", n), {20'h0, act}, {20'h0, e.beat});
    if (chk_lat) check($sformatf("out%0d_latency", n), cyc, e.stamp + 1);
  endtask

  // One clock: drive at negedge, sample 1 ns later, handshakes complete at the next posedge.
  task automatic cycle(input logic v, input vec_t b, output bit acc);
    @(negedge clk);
    cyc++;
    in_if.val  = v;
    in_if.data = b.data;
    in_if.sof  = b.sof;
    in_if.eof  = b.eof;
    in_if.sol  = b.sol;
    in_if.eol  = b.eol;
    sel        = b.sel;
    o0_if.rdy  = rnd_rdy ? ($urandom_range(0, 3) != 0) : r0;
    o1_if.rdy  = rnd_rdy ? ($urandom_range(0, 3) != 0) : r1;
    #1;
    check("one_hot_val", {31'h0, o0_if.val & o1_if.val}, 32'h0);
    if (o0_if.val && o0_if.rdy) pop_chk(0, {o0_if.data, o0_if.sof, o0_if.eof, o0_if.sol, o0_if.eol});
    if (o1_if.val && o1_if.rdy) pop_chk(1, {o1_if.data, o1_if.sof, o1_if.eof, o1_if.sol, o1_if.eol});
    acc = v & in_if.rdy;
  endtask

  task automatic send(input vec_t b, output int tries);
    bit   acc;
    logic v;
    exp_t e;
    tries = 0;
    acc   = 1'b0;
    do begin
      v = rnd_val ? ($urandom_range(0, 2) != 0) : 1'b1;
      cycle(v, b, acc);
      tries++;
      if (b.chk_rdy && v) check("in_rdy_drop", {31'h0, in_if.rdy}, 32'h1);
    end while (!acc && tries < 300);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept of data %0h", b.data);
    end else begin
      e.beat  = {b.data, b.sof, b.eof, b.sol, b.eol};
      e.stamp = cyc;
      if (b.exp_dest == 0)      q0.push_back(e);
      else if (b.exp_dest == 1) q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    vec_t z;
    bit   acc;
    z = mk(1'b0, 1, 8'h00, 2, 1'b0);
    z.sol = 1'b0;
    for (int i = 0; i < n; i++) cycle(1'b0, z, acc);
  endtask

  task automatic drain();
    int n;
    rnd_rdy = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      idle(1);
      n++;
    end
    idle(1);
    check("q0_empty", q0.size(), 32'h0);
    check("q1_empty", q1.size(), 32'h0);
  endtask

  vec_t tbl[27];

  initial begin
    int   tries;
    bit   acc;
    vec_t v;
    logic [7:0] d;

    for (int i = 0; i < 8; i++) tbl[i]      = mk(1'b0,       i,     8'h10 + 8'(i), 0, 1'b0);
    for (int i = 0; i < 8; i++) tbl[8 + i]  = mk(logic'(i < 3), i,  8'h20 + 8'(i), 1, 1'b0);
    for (int i = 0; i < 3; i++) tbl[16 + i] = mk(1'b0,       i + 1, 8'h30 + 8'(i), 2, 1'b1);
    for (int i = 0; i < 8; i++) tbl[19 + i] = mk(1'b1,       i,     8'h40 + 8'(i), 1, 1'b0);

    rst = 1'b1;
    sel = 1'b0;
    in_if.val = 1'b0; in_if.data = '0;
    in_if.sof = 1'b0; in_if.eof = 1'b0; in_if.sol = 1'b0; in_if.eol = 1'b0;
    o0_if.rdy = 1'b1; o1_if.rdy = 1'b1;
    idle(3);
    check("rst_out0_val", {31'h0, o0_if.val}, 32'h0);
    check("rst_out1_val", {31'h0, o1_if.val}, 32'h0);
    check("rst_in_rdy",   {31'h0, in_if.rdy}, 32'h1);
    check("rst_data",     {24'h0, o0_if.data}, 32'h0);
`ifdef FRM_DEMUX_CNT_EN
    check("rst_cnt0", {16'h0, frm_cnt0}, 32'h0);
    check("rst_cnt1", {16'h0, frm_cnt1}, 32'h0);
`endif
    rst = 1'b0;

    // Basic routing, mid-frame sel toggle, stray-beat drop: full rate, 1-clk latency.
    chk_lat = 1'b1;
    for (int k = 0; k < 27; k++) begin
      send(tbl[k], tries);
      check($sformatf("throughput_%0d", k), tries, 32'h1);
    end
    drain();
    chk_lat = 1'b0;

    // Frame A tail stalled on out0; frame B sof (to out1) must wait behind it.
    for (int i = 0; i < 8; i++) send(mk(1'b0, i, 8'h50 + 8'(i), 0, 1'b0), tries);
    r0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, mk(1'b1, 0, 8'h60, 1, 1'b0), acc);
      check("b_sof_blocked", {31'h0, acc}, 32'h0);
    end
    r0 = 1'b1;
    for (int i = 0; i < 8; i++) send(mk(1'b1, i, 8'h60 + 8'(i), 1, 1'b0), tries);
    drain();

    // 100 frames alternating destination under random stalls and sel noise.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rnd_val = 1'b1;
    rnd_rdy = 1'b1;
    d = 8'h00;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 8; i++) begin
        v = mk(logic'(f % 2), i, d, f % 2, 1'b0);
        if (i != 0) v.sel = logic'($urandom_range(0, 1));
        send(v, tries);
        d++;
      end
    end
    rnd_val = 1'b0;
    drain();
`ifdef FRM_DEMUX_CNT_EN
    check("cnt0_100", {16'h0, frm_cnt0}, 32'd50);
    check("cnt1_100", {16'h0, frm_cnt1}, 32'd50);
`endif

    // Reset mid-frame while a beat is held; rest of that frame must be discarded.
    r0 = 1'b0;
    send(mk(1'b0, 0, 8'hA0, 2, 1'b0), tries);
    cycle(1'b1, mk(1'b0, 1, 8'hA1, 2, 1'b0), acc);
    check("held_blocks", {31'h0, acc}, 32'h0);
    check("held_val", {31'h0, o0_if.val}, 32'h1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    r0 = 1'b1;
    check("mrst_out0_val", {31'h0, o0_if.val}, 32'h0);
    check("mrst_out1_val", {31'h0, o1_if.val}, 32'h0);
    check("mrst_in_rdy",   {31'h0, in_if.rdy}, 32'h1);
`ifdef FRM_DEMUX_CNT_EN
    check("mrst_cnt0", {16'h0, frm_cnt0}, 32'h0);
    check("mrst_cnt1", {16'h0, frm_cnt1}, 32'h0);
`endif
    for (int i = 1; i < 8; i++) send(mk(1'b1, i, 8'hA0 + 8'(i), 2, 1'b1), tries);
    for (int i = 0; i < 8; i++) send(mk(1'b1, i, 8'hB0 + 8'(i), 1, 1'b0), tries);
    drain();
`ifdef FRM_DEMUX_CNT_EN
    check("post_cnt1", {16'h0, frm_cnt1}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
